is2vid_control_gen2: RTL and testbench
======================================

# is2vid_control_gen2

Parametrised control/status register block for the ImageStream-to-video output stage, succeeding the first-generation IS2Vid control slave. It decodes an Avalon-MM slave port, holds enable and genlock controls, and forwards mode-bank writes to the mode registers with an acknowledge handshake and timeout. It adds four maskable sticky interrupt sources (mode change, genlock change, underflow, FIFO low-watermark), a programmable watermark and a saturating underflow counter. It sits between the host CPU bus and the IS2Vid FIFO/mode-register logic.

## Interface
- DATA_WIDTH, 16: Avalon data width; 16 or 32.
- NO_OF_MODES, 1: mode count, 1..32; match vector is zero-extended or truncated to DATA_WIDTH.
- USED_WORDS_WIDTH, 15: FIFO fill-level width, ≤ DATA_WIDTH.
- ACK_TIMEOUT, 255: maximum cycles waiting for av_write_ack; 0 disables the timeout.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- av_write_ack  in  1  mode registers accepted a forwarded write.
- mode_change  in  1  one-cycle pulse: mode_match is valid.
- mode_match  in  NO_OF_MODES  matched-mode vector.
- usedw  in  USED_WORDS_WIDTH  FIFO fill level.
- underflow_sticky  in  1  FIFO underflow flag, held until cleared.
- enable_resync  in  1  from the output state machine.
- genlocked  in  1  genlock status.
- enable  out  1  output enable, control bit 0.
- genlock_enable  out  2  control bits [6:5].
- clear_underflow_sticky  out  1  held high until underflow_sticky falls.
- write_trigger  out  1  forwarded mode-bank write strobe.
- write_trigger_ack  out  1  av_write_ack delayed by one cycle.
- av_address  in  8  word address.
- av_read, av_write  in  1  bus strobes.
- av_writedata  in  DATA_WIDTH  write data.
- av_readdata  out  DATA_WIDTH  combinational read data.
- av_waitrequest  out  1  stalls forwarded writes.
- status_update_int  out  1  OR of all pending interrupt bits.

## Operation
- Address map. Unused bits read 0.
  - 0 CTRL (R/W): [0] enable; [4:1] int_en for mode, genlock, underflow and watermark; [6:5] genlock_enable.
  - 1 STATUS: [0] enable_resync; [2] underflow_sticky (writing 1 starts the clear); [3] genlocked; [4] ack_timeout_err (W1C).
  - 2 INT (W1C): [1] mode, [2] genlock, [3] underflow, [4] watermark.
  - 3: usedw (read-only).
  - 4: latched mode_match (read-only).
  - 5 WMARK (R/W): threshold.
  - 6 UFCNT: 16-bit saturating count of underflow_sticky rising edges; any write clears it.
  - 7: reads 0; writes are ignored.
  - ≥8: forwarded writes.
- Interrupt set events:
  - mode: mode_change.
  - genlock: genlocked differs from its registered copy.
  - underflow: rising edge of underflow_sticky.
  - watermark: usedw<WMARK while the registered compare was usedw≥WMARK.
- Each INT bit is ANDed with its int_en bit. Clearing int_en clears the pending bit.
- If a set event and a W1C clear land in the same cycle, the bit stays set.
- Latched mode_match updates only on mode_change.
- clear_underflow_sticky sets on a STATUS write with bit 2 = 1. It stays high until underflow_sticky is low, then clears the following cycle.
- Forwarded write handshake, a two-state FSM:
  - IDLE: on av_write with address ≥8, go to WAIT with the counter at 0.
  - WAIT: the counter increments each cycle. On av_write_ack, return to IDLE. If the counter reaches ACK_TIMEOUT and ACK_TIMEOUT≠0, set ack_timeout_err, raise a one-cycle done, and return to IDLE.
  - write_trigger = av_write & addr≥8 & ~done.
  - av_waitrequest = av_write & addr≥8 & ~av_write_ack & ~done.
  - Registers at addresses <8 never stall.
- UFCNT saturates at 0xFFFF. A write to UFCNT in the same cycle as an increment event leaves UFCNT at 0.

## Timing
- Reset (rst_n low, asynchronous): every register is 0, including WMARK. Outputs enable, genlock_enable, clear_underflow_sticky, write_trigger_ack and status_update_int are 0. FSM is IDLE.
- Combinational outputs after reset: av_readdata is 0 for an idle bus at address 0. av_waitrequest and write_trigger follow the bus strobes.
- Register writes take effect on the next edge. Reads are zero-wait and combinational.
- Interrupt latency: event at edge N → INT bit and status_update_int high after edge N+1.
- A timed-out write holds waitrequest for exactly ACK_TIMEOUT cycles. It releases in the following cycle.
- Reset asserted mid-handshake aborts to IDLE with no error flag.

## Test plan
- Reset, then read addresses 0–6 → all 0. Write CTRL=0x7F → enable=1, genlock_enable=3, readback 0x7F.
- Set int_en[1]=1 and pulse mode_change with mode_match=0x5. → INT=0x2 and register 4 reads 0x5. Write INT=0x2 → cleared. Repeat with the mode_change pulse in the same cycle as the clear → bit stays set.
- WMARK=100 and watermark int enabled. Ramp usedw 120→99 → watermark bit sets once. Hold usedw at 99 → no further set.
- Pulse underflow_sticky three times (rise/fall) → UFCNT=3 and the underflow INT bit is set. Write STATUS bit2 → clear_underflow_sticky stays high until underflow_sticky is low.
- Write address 8 with ack returned after 3 cycles → waitrequest high 3 cycles, write_trigger_ack one cycle after ack, no error.
- ACK_TIMEOUT=4, write address 9 with no ack → waitrequest high 4 cycles, then released. STATUS[4]=1; W1C clears it.

Source files
------------

// File: rtl/is2vid_control_gen2_if.sv
// Avalon-MM slave bus bundle for the IS2Vid control/status block.
interface is2vid_control_gen2_if #(
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            av_address;
  logic                  av_read;
  logic                  av_write;
  logic [DATA_WIDTH-1:0] av_writedata;
  logic [DATA_WIDTH-1:0] av_readdata;
  logic                  av_waitrequest;

  modport master (
    output av_address, av_read, av_write, av_writedata,
    input  av_readdata, av_waitrequest
  );

  modport slave (
    input  av_address, av_read, av_write, av_writedata,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/is2vid_control_gen2.sv
// IS2Vid control/status register block: CTRL/STATUS/INT registers, FIFO
// watermark and underflow counter, plus forwarding of mode-bank writes
// (address >= 8) with an acknowledge handshake and optional timeout.
module is2vid_control_gen2 #(
  parameter int DATA_WIDTH       = 16,
  parameter int NO_OF_MODES      = 1,
  parameter int USED_WORDS_WIDTH = 15,
  parameter int ACK_TIMEOUT      = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        av_write_ack,
  input  logic                        mode_change,
  input  logic [NO_OF_MODES-1:0]      mode_match,
  input  logic [USED_WORDS_WIDTH-1:0] usedw,
  input  logic                        underflow_sticky,
  input  logic                        enable_resync,
  input  logic                        genlocked,
  output logic                        enable,
  output logic [1:0]                  genlock_enable,
  output logic                        clear_underflow_sticky,
  output logic                        write_trigger,
  output logic                        write_trigger_ack,
  output logic                        status_update_int,
  is2vid_control_gen2_if.slave        bus
);

  localparam int UW    = USED_WORDS_WIDTH;
  localparam int CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W:0] TIMEOUT_V = (CNT_W + 1)'(ACK_TIMEOUT);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W:0]         cnt_inc;
  logic                   done;

  logic                   enable_q, enable_d;
  logic [3:0]             int_en_q, int_en_d;
  logic [1:0]             genlock_enable_q, genlock_enable_d;
  logic [3:0]             int_q, int_d;           // {watermark, underflow, genlock, mode}
  logic                   ack_err_q, ack_err_d;
  logic                   clear_uf_q, clear_uf_d;
  logic [UW-1:0]          wmark_q, wmark_d;
  logic [15:0]            ufcnt_q, ufcnt_d;
  logic [NO_OF_MODES-1:0] mode_match_q, mode_match_d;
  logic                   genlocked_q;
  logic                   uf_prev_q;
  logic                   wm_above_q;
  logic                   wta_q;

  logic                   fwd_wr;
  logic                   wr_ctrl, wr_status, wr_int, wr_wmark, wr_ufcnt;
  logic                   uf_rise, gl_ev, wm_ev;
  logic [3:0]             ev, w1c;
  logic [DATA_WIDTH-1:0]  mm_ext;
  logic [DATA_WIDTH-1:0]  rd;
  logic                   unused_bits;

  assign fwd_wr    = bus.av_write & (bus.av_address[7:3] != 5'd0);
  assign wr_ctrl   = bus.av_write & (bus.av_address == 8'd0);
  assign wr_status = bus.av_write & (bus.av_address == 8'd1);
  assign wr_int    = bus.av_write & (bus.av_address == 8'd2);
  assign wr_wmark  = bus.av_write & (bus.av_address == 8'd5);
  assign wr_ufcnt  = bus.av_write & (bus.av_address == 8'd6);

  assign uf_rise = underflow_sticky & ~uf_prev_q;
  assign gl_ev   = genlocked ^ genlocked_q;
  // Falling through the watermark: below now, at-or-above last cycle.
  assign wm_ev   = (usedw < wmark_q) & wm_above_q;
  assign ev      = {wm_ev, uf_rise, gl_ev, mode_change};

  // Match vector zero-extended or truncated to the bus width.
  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_mm
    if (gi < NO_OF_MODES) begin : g_bit
      assign mm_ext[gi] = mode_match_q[gi];
    end else begin : g_zero
      assign mm_ext[gi] = 1'b0;
    end
  end

  assign unused_bits = ^{bus.av_writedata, mode_match_q};

  // Forwarded-write handshake: next state, wait counter and timeout strobe.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    case (state_q)
      S_IDLE: begin
        if (fwd_wr && !av_write_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_inc[CNT_W-1:0];
        if (av_write_ack) begin
          state_d = S_IDLE;
        end else if ((ACK_TIMEOUT != 0) && (cnt_inc == TIMEOUT_V)) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register file next-state: control, sticky interrupts, watermark, counter.
  always_comb begin
    enable_d         = wr_ctrl ? bus.av_writedata[0]   : enable_q;
    int_en_d         = wr_ctrl ? bus.av_writedata[4:1] : int_en_q;
    genlock_enable_d = wr_ctrl ? bus.av_writedata[6:5] : genlock_enable_q;
    wmark_d          = wr_wmark ? bus.av_writedata[UW-1:0] : wmark_q;
    mode_match_d     = mode_change ? mode_match : mode_match_q;

    // A set event wins over a same-cycle W1C; disabling a source drops it.
    w1c   = wr_int ? bus.av_writedata[4:1] : 4'b0000;
    int_d = ((int_q & ~w1c) | ev) & int_en_d;

    ack_err_d = done | (ack_err_q & ~(wr_status & bus.av_writedata[4]));

    clear_uf_d = clear_uf_q;
    if (wr_status && bus.av_writedata[2]) begin
      clear_uf_d = 1'b1;
    end else if (!underflow_sticky) begin
      clear_uf_d = 1'b0;
    end

    ufcnt_d = ufcnt_q;
    if (wr_ufcnt) begin
      ufcnt_d = 16'h0000;
    end else if (uf_rise && (ufcnt_q != 16'hFFFF)) begin
      ufcnt_d = ufcnt_q + 16'h0001;
    end
  end

  // Zero-wait read mux; unused bits and unmapped addresses read 0.
  always_comb begin
    rd = '0;
    case (bus.av_address)
      8'd0: rd[6:0]    = {genlock_enable_q, int_en_q, enable_q};
      8'd1: rd[4:0]    = {ack_err_q, genlocked, underflow_sticky, 1'b0, enable_resync};
      8'd2: rd[4:0]    = {int_q, 1'b0};
      8'd3: rd[UW-1:0] = usedw;
      8'd4: rd         = mm_ext;
      8'd5: rd[UW-1:0] = wmark_q;
      8'd6: rd[15:0]   = ufcnt_q;
      default: rd      = '0;
    endcase
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      enable_q         <= 1'b0;
      int_en_q         <= 4'b0000;
      genlock_enable_q <= 2'b00;
      int_q            <= 4'b0000;
      ack_err_q        <= 1'b0;
      clear_uf_q       <= 1'b0;
      wmark_q          <= '0;
      ufcnt_q          <= 16'h0000;
      mode_match_q     <= '0;
      genlocked_q      <= 1'b0;
      uf_prev_q        <= 1'b0;
      wm_above_q       <= 1'b0;
      wta_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      enable_q         <= enable_d;
      int_en_q         <= int_en_d;
      genlock_enable_q <= genlock_enable_d;
      int_q            <= int_d;
      ack_err_q        <= ack_err_d;
      clear_uf_q       <= clear_uf_d;
      wmark_q          <= wmark_d;
      ufcnt_q          <= ufcnt_d;
      mode_match_q     <= mode_match_d;
      genlocked_q      <= genlocked;
      uf_prev_q        <= underflow_sticky;
      wm_above_q       <= (usedw >= wmark_q);
      wta_q            <= av_write_ack;
    end
  end

  assign enable                 = enable_q;
  assign genlock_enable         = genlock_enable_q;
  assign clear_underflow_sticky = clear_uf_q;
  assign write_trigger_ack      = wta_q;
  assign status_update_int      = |int_q;
  assign write_trigger          = fwd_wr & ~done;
  assign bus.av_waitrequest     = fwd_wr & ~av_write_ack & ~done;
  assign bus.av_readdata        = bus.av_read ? rd : '0;

endmodule

// File: tb/tb_is2vid_control_gen2.sv
// Self-checking bench for is2vid_control_gen2: table of register accesses,
// then hand-written sequences for interrupts, watermark, underflow and the
// forwarded-write handshake. Expected values go through a scoreboard queue.
module tb_is2vid_control_gen2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        av_write_ack = 1'b0;
  logic        mode_change = 1'b0;
  logic [7:0]  mode_match = 8'h00;
  logic [14:0] usedw = 15'd0;
  logic        underflow_sticky = 1'b0;
  logic        enable_resync = 1'b0;
  logic        genlocked = 1'b0;
  logic        enable;
  logic [1:0]  genlock_enable;
  logic        clear_underflow_sticky;
  logic        write_trigger;
  logic        write_trigger_ack;
  logic        status_update_int;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] sb_q[$];
  string       sb_name_q[$];

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  is2vid_control_gen2_if #(.DATA_WIDTH(16)) bus_if ();

  is2vid_control_gen2 #(
    .DATA_WIDTH(16), .NO_OF_MODES(8), .USED_WORDS_WIDTH(15), .ACK_TIMEOUT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .av_write_ack(av_write_ack),
    .mode_change(mode_change), .mode_match(mode_match), .usedw(usedw),
    .underflow_sticky(underflow_sticky), .enable_resync(enable_resync),
    .genlocked(genlocked), .enable(enable), .genlock_enable(genlock_enable),
    .clear_underflow_sticky(clear_underflow_sticky),
    .write_trigger(write_trigger), .write_trigger_ack(write_trigger_ack),
    .status_update_int(status_update_int), .bus(bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_name_q.push_back(name);
    sb_q.push_back(exp);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    string       n;
    logic [31:0] e;
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got 0x%0h expected a queued value", act);
    end else begin
      n = sb_name_q.pop_front();
      e = sb_q.pop_front();
      check(n, act, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] addr, input logic [15:0] data);
    bus_if.av_address   = addr;
    bus_if.av_writedata = data;
    bus_if.av_write     = 1'b1;
    tick();
    bus_if.av_write     = 1'b0;
    $display("wr   addr=%0d data=0x%0h", addr, data);
  endtask

  task automatic bus_read(input logic [7:0] addr, input logic [15:0] exp);
    bus_if.av_address = addr;
    bus_if.av_read    = 1'b1;
    sb_push($sformatf("read_addr%0d", addr), {16'h0, exp});
    @(negedge clk);
    sb_pop({16'h0, bus_if.av_readdata});
    tick();
    bus_if.av_read = 1'b0;
  endtask

  // Forwarded write; ack_after < 0 means no ack (timeout path).
  task automatic fwd_write(input logic [7:0] addr, input int ack_after, input int exp_cycles);
    int   cnt;
    logic trig;
    bus_if.av_address   = addr;
    bus_if.av_writedata = 16'hA5A5;
    bus_if.av_write     = 1'b1;
    sb_push($sformatf("wait_cycles_addr%0d", addr), exp_cycles);
    sb_push("trigger_at_release", (ack_after >= 0) ? 32'd1 : 32'd0);
    sb_push("write_trigger_ack", (ack_after >= 0) ? 32'd1 : 32'd0);
    cnt  = 0;
    trig = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c == ack_after) av_write_ack = 1'b1;
      @(negedge clk);
      if (!bus_if.av_waitrequest) begin
        trig = write_trigger;
        break;
      end
      cnt++;
      tick();
    end
    sb_pop(cnt);
    sb_pop({31'h0, trig});
    tick();
    bus_if.av_write = 1'b0;
    av_write_ack    = 1'b0;
    @(negedge clk);
    sb_pop({31'h0, write_trigger_ack});
    tick();
  endtask

  initial begin
    bus_if.av_address   = 8'd0;
    bus_if.av_read      = 1'b0;
    bus_if.av_write     = 1'b0;
    bus_if.av_writedata = 16'h0;

    vecs[0]  = '{1'b0, 8'd0, 16'h0000, 16'h0000};
    vecs[1]  = '{1'b0, 8'd1, 16'h0000, 16'h0000};
    vecs[2]  = '{1'b0, 8'd2, 16'h0000, 16'h0000};
    vecs[3]  = '{1'b0, 8'd3, 16'h0000, 16'h0000};
    vecs[4]  = '{1'b0, 8'd4, 16'h0000, 16'h0000};
    vecs[5]  = '{1'b0, 8'd5, 16'h0000, 16'h0000};
    vecs[6]  = '{1'b0, 8'd6, 16'h0000, 16'h0000};
    vecs[7]  = '{1'b1, 8'd7, 16'hFFFF, 16'h0000};
    vecs[8]  = '{1'b0, 8'd7, 16'h0000, 16'h0000};
    vecs[9]  = '{1'b1, 8'd0, 16'h007F, 16'h0000};
    vecs[10] = '{1'b0, 8'd0, 16'h0000, 16'h007F};
    vecs[11] = '{1'b0, 8'd2, 16'h0000, 16'h0000};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_enable", {31'h0, enable}, 32'd0);
    check("rst_genlock_enable", {30'h0, genlock_enable}, 32'd0);
    check("rst_clear_uf", {31'h0, clear_underflow_sticky}, 32'd0);
    check("rst_wt_ack", {31'h0, write_trigger_ack}, 32'd0);
    check("rst_int", {31'h0, status_update_int}, 32'd0);
    check("rst_waitrequest", {31'h0, bus_if.av_waitrequest}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven register accesses
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else            bus_read(vecs[i].addr, vecs[i].exp);
    end
    check("ctrl_enable", {31'h0, enable}, 32'd1);
    check("ctrl_genlock_enable", {30'h0, genlock_enable}, 32'd3);

    // Mode interrupt, latch and W1C collision
    bus_write(8'd0, 16'h0003);
    mode_change = 1'b1;
    mode_match  = 8'h05;
    tick();
    mode_change = 1'b0;
    mode_match  = 8'h03;
    bus_read(8'd2, 16'h0002);
    check("mode_status_int", {31'h0, status_update_int}, 32'd1);
    bus_read(8'd4, 16'h0005);
    bus_write(8'd2, 16'h0002);
    bus_read(8'd2, 16'h0000);
    check("mode_int_cleared", {31'h0, status_update_int}, 32'd0);
    mode_change = 1'b1;
    bus_write(8'd2, 16'h0002);
    mode_change = 1'b0;
    bus_read(8'd2, 16'h0002);
    bus_read(8'd4, 16'h0003);

    // Watermark (disabling mode int_en also drops the pending mode bit)
    usedw = 15'd120;
    bus_write(8'd0, 16'h0011);
    bus_read(8'd2, 16'h0000);
    bus_write(8'd5, 16'd100);
    bus_read(8'd5, 16'd100);
    for (int u = 120; u >= 99; u--) begin
      usedw = 15'(u);
      tick();
    end
    bus_read(8'd2, 16'h0010);
    bus_write(8'd2, 16'h0010);
    repeat (3) tick();
    bus_read(8'd2, 16'h0000);
    bus_read(8'd3, 16'd99);

    // Underflow counter, interrupt and clear handshake
    bus_write(8'd0, 16'h0009);
    for (int p = 0; p < 3; p++) begin
      underflow_sticky = 1'b1;
      tick();
      underflow_sticky = 1'b0;
      tick();
    end
    bus_read(8'd6, 16'd3);
    bus_read(8'd2, 16'h0008);
    underflow_sticky = 1'b1;
    tick();
    bus_write(8'd1, 16'h0004);
    check("clear_uf_set", {31'h0, clear_underflow_sticky}, 32'd1);
    bus_read(8'd1, 16'h0004);
    repeat (3) tick();
    check("clear_uf_held", {31'h0, clear_underflow_sticky}, 32'd1);
    underflow_sticky = 1'b0;
    @(negedge clk);
    check("clear_uf_before_edge", {31'h0, clear_underflow_sticky}, 32'd1);
    tick();
    check("clear_uf_released", {31'h0, clear_underflow_sticky}, 32'd0);
    bus_read(8'd6, 16'd4);
    underflow_sticky = 1'b1;
    bus_write(8'd6, 16'h0000);
    underflow_sticky = 1'b0;
    bus_read(8'd6, 16'd0);

    // Forwarded write acked after 3 cycles, then a timed-out write
    fwd_write(8'd8, 3, 3);
    check("wt_ack_one_cycle", {31'h0, write_trigger_ack}, 32'd0);
    bus_read(8'd1, 16'h0000);
    fwd_write(8'd9, -1, 4);
    bus_read(8'd1, 16'h0010);
    bus_write(8'd1, 16'h0010);
    bus_read(8'd1, 16'h0000);

    // Genlock interrupt and status inputs
    bus_write(8'd0, 16'h0005);
    genlocked     = 1'b1;
    enable_resync = 1'b1;
    tick();
    bus_read(8'd2, 16'h0004);
    bus_read(8'd1, 16'h0009);

    // Reset mid-handshake, then a clean timeout proves the FSM is idle
    bus_if.av_address = 8'd8;
    bus_if.av_write   = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    bus_if.av_write = 1'b0;
    genlocked       = 1'b0;
    enable_resync   = 1'b0;
    @(negedge clk);
    check("midrst_enable", {31'h0, enable}, 32'd0);
    check("midrst_int", {31'h0, status_update_int}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus_read(8'd1, 16'h0000);
    fwd_write(8'd10, -1, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
